bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 9 +
 rtl/bus_arbiter_if.sv | 6 +
 rtl/bus_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state encoding and master IDs for the bus arbiter.
package bus_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t GNT_M0 = 2'd1;
  localparam state_t GNT_M1 = 2'd2;
  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between two masters and the arbiter.
interface bus_arbiter_if;
  logic m0_req, m1_req, m0_grant, m1_grant, msel, bus_busy, timeout_flag;
  modport master(output m0_req, m1_req, input m0_grant, m1_grant, msel, bus_busy, timeout_flag);
  modport slave(input m0_req, m1_req, output m0_grant, m1_grant, msel, bus_busy, timeout_flag);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter; BUS_ARB_TIMEOUT_EN adds tenure-limit preemption.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  bus_arbiter_if.slave bus
);
  state_t r_state, w_nxt;
  logic r_last, r_msel, r_g0, r_g1, r_busy, w_to;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end
`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt;
  logic r_tf;
  assign w_to = r_cnt == LIM && (r_state == GNT_M0 ? bus.m1_req : r_state == GNT_M1 && bus.m0_req);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
      r_tf <= 1'b0;
    end else begin
      r_tf <= w_to;
      r_cnt <= w_nxt != r_state ? 8'd0 : (r_state != IDLE && r_cnt != LIM) ? r_cnt + 8'd1 : r_cnt;
    end
  end
  assign bus.timeout_flag = r_tf;
`else
  assign w_to = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state == IDLE ? (bus.m0_req && bus.m1_req ? (r_last == MASTER1 ? GNT_M0 : GNT_M1) :
                               bus.m0_req ? GNT_M0 : bus.m1_req ? GNT_M1 : IDLE) :
            r_state == GNT_M0 ? (bus.m0_req && !w_to ? GNT_M0 : bus.m1_req ? GNT_M1 : IDLE) :
            r_state == GNT_M1 ? (bus.m1_req && !w_to ? GNT_M1 : bus.m0_req ? GNT_M0 : IDLE) :
            IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= MASTER1;
      r_msel <= MASTER0;
      r_g0 <= 1'b0;
      r_g1 <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_g0 <= w_nxt == GNT_M0;
      r_g1 <= w_nxt == GNT_M1;
      r_busy <= w_nxt != IDLE;
      if (w_nxt != IDLE && w_nxt != r_state) begin
        r_last <= w_nxt == GNT_M1;
        r_msel <= w_nxt == GNT_M1;
      end
    end
  end
  assign bus.m0_grant = r_g0;
  assign bus.m1_grant = r_g1;
  assign bus.msel = r_msel;
  assign bus.bus_busy = r_busy;
endmodule
